// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM encoding, instruction field positions
// and the default sequential PC increment.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

  localparam int PC_STEP_DEF = 4;

  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int SH_LSB  = 6;
  localparam int FN_LSB  = 0;

  localparam int OPC_W = 6;
  localparam int REG_W = 5;
  localparam int FN_W  = 6;
  localparam int IMM_W = 16;
  localparam int JA_W  = 26;

endpackage

// File: rtl/instr_fetch_unit_split.sv
// Pure combinational slicer of an instruction word into its fields.
// Shared between fetch and decode.
module instr_field_split
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0]      ir,
  output logic [OPC_W-1:0] opcode,
  output logic [REG_W-1:0] rs,
  output logic [REG_W-1:0] rt,
  output logic [REG_W-1:0] rd,
  output logic [REG_W-1:0] shamt,
  output logic [FN_W-1:0]  funct,
  output logic [IMM_W-1:0] imm16,
  output logic [JA_W-1:0]  jaddr
);

  assign opcode = ir[OPC_LSB +: OPC_W];
  assign rs     = ir[RS_LSB  +: REG_W];
  assign rt     = ir[RT_LSB  +: REG_W];
  assign rd     = ir[RD_LSB  +: REG_W];
  assign shamt  = ir[SH_LSB  +: REG_W];
  assign funct  = ir[FN_LSB  +: FN_W];
  assign imm16  = ir[0 +: IMM_W];
  assign jaddr  = ir[0 +: JA_W];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, word request to imem, instruction register and
// field outputs, with branch redirect even while a fetch is in flight.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ir_valid,
  input  logic        ir_accept,
  input  logic        stall,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] ir_pc_plus4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr
);

  localparam logic [31:0] STEP = 32'(PC_STEP);
  localparam logic [31:0] PC0  = RESET_PC & ~32'h3;

  fetch_state_e state, state_nx;

  logic [31:0] pc;
  logic [31:0] pc_redirect;
  logic [31:0] tgt;
  logic        take;

  assign tgt  = pc_target & ~32'h3;
  assign take = ir_valid & ir_accept & ~stall;

  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_REQ: begin
        if (pc_load & ~mem_ack)      state_nx = S_FLUSH;
        else if (mem_ack & ~pc_load) state_nx = S_HOLD;
      end
      S_HOLD: begin
        if (pc_load | take) state_nx = S_REQ;
      end
      S_FLUSH: begin
        if (mem_ack) state_nx = S_REQ;
      end
      default: state_nx = S_REQ;
    endcase
  end

  // The request is dropped during reset so an in-flight fetch is abandoned.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = pc;
    unique case (state)
      S_REQ:   mem_req = ~reset;
      S_FLUSH: mem_req = ~reset;
      default: mem_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= PC0;
      pc_redirect <= PC0;
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
    end else begin
      unique case (state)
        S_REQ: begin
          if (pc_load & mem_ack) begin
            pc <= tgt;
          end else if (pc_load) begin
            pc_redirect <= tgt;
          end else if (mem_ack) begin
            ir       <= mem_rdata;
            ir_pc    <= pc;
            pc       <= pc + STEP;
            ir_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (pc_load) begin
            pc       <= tgt;
            ir_valid <= 1'b0;
          end else if (take) begin
            ir_valid <= 1'b0;
          end
        end
        S_FLUSH: begin
          // A redirect arriving with the ack beats the stored one.
          if (mem_ack) pc <= pc_load ? tgt : pc_redirect;
          else if (pc_load) pc_redirect <= tgt;
        end
        default: ;
      endcase
    end
  end

  assign ir_pc_plus4 = ir_pc + STEP;

  instr_field_split u_split (
    .ir     (ir),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .funct  (funct),
    .imm16  (imm16),
    .jaddr  (jaddr)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, handshakes, redirects,
// PC wrap and reset during an outstanding fetch.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ir_valid;
  logic        ir_accept;
  logic        stall;
  logic        pc_load;
  logic [31:0] pc_target;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [31:0] ir_pc_plus4;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] jaddr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ir_valid    (ir_valid),
    .ir_accept   (ir_accept),
    .stall       (stall),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_pc_plus4 (ir_pc_plus4),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .imm16       (imm16),
    .jaddr       (jaddr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    ir_accept = 1'b0;
    stall     = 1'b0;
    pc_load   = 1'b0;
    pc_target = '0;
    tick();
    tick();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_vld", 32'(ir_valid), 32'd0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_irpc", ir_pc, 32'h0);

    reset = 1'b0;
    #1;
    chk("req0", 32'(mem_req), 32'd1);
    chk("addr0", mem_addr, 32'h0);
    tick();
    chk("addr0_hold", mem_addr, 32'h0);
    mem_ack = 1'b1;
    mem_rdata = 32'h2008_FFFF;
    tick();
    mem_ack = 1'b0;
    chk("v1", 32'(ir_valid), 32'd1);
    chk("opc1", 32'(opcode), 32'h08);
    chk("rs1", 32'(rs), 32'd0);
    chk("rt1", 32'(rt), 32'd8);
    chk("imm1", 32'(imm16), 32'hFFFF);
    chk("irpc1", ir_pc, 32'h0);
    chk("pc4_1", ir_pc_plus4, 32'h4);
    chk("hold_req", 32'(mem_req), 32'd0);

    stall = 1'b1;
    ir_accept = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_vld", 32'(ir_valid), 32'd1);
    chk("stall_ir", ir, 32'h2008_FFFF);
    chk("stall_req", 32'(mem_req), 32'd0);
    stall = 1'b0;
    tick();
    ir_accept = 1'b0;
    chk("acc_vld", 32'(ir_valid), 32'd0);
    chk("addr4", mem_addr, 32'h4);
    chk("req4", 32'(mem_req), 32'd1);

    mem_ack = 1'b1;
    mem_rdata = 32'h012A_4020;
    tick();
    mem_ack = 1'b0;
    chk("v2", 32'(ir_valid), 32'd1);
    chk("irpc2", ir_pc, 32'h4);
    chk("rs2", 32'(rs), 32'd9);
    chk("rt2", 32'(rt), 32'd10);
    chk("rd2", 32'(rd), 32'd8);
    chk("sh2", 32'(shamt), 32'd0);
    chk("fn2", 32'(funct), 32'h20);
    ir_accept = 1'b1;
    tick();
    ir_accept = 1'b0;
    chk("addr8", mem_addr, 32'h8);

    pc_load = 1'b1;
    pc_target = 32'h0000_0103;
    tick();
    pc_load = 1'b0;
    chk("fl_addr", mem_addr, 32'h8);
    chk("fl_req", 32'(mem_req), 32'd1);
    tick();
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ack = 1'b0;
    chk("fl_vld", 32'(ir_valid), 32'd0);
    chk("fl_ir", ir, 32'h012A_4020);
    chk("addr100", mem_addr, 32'h100);
    tick();
    chk("fl_vld2", 32'(ir_valid), 32'd0);

    mem_ack = 1'b1;
    mem_rdata = 32'h8C43_0010;
    tick();
    mem_ack = 1'b0;
    chk("v3", 32'(ir_valid), 32'd1);
    chk("irpc3", ir_pc, 32'h100);
    chk("imm3", 32'(imm16), 32'h0010);
    pc_load = 1'b1;
    pc_target = 32'h40;
    ir_accept = 1'b1;
    tick();
    pc_load = 1'b0;
    ir_accept = 1'b0;
    chk("hl_vld", 32'(ir_valid), 32'd0);
    chk("addr40", mem_addr, 32'h40);

    pc_load = 1'b1;
    pc_target = 32'hFFFF_FFFC;
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_1111;
    tick();
    pc_load = 1'b0;
    mem_ack = 1'b0;
    chk("ld_ack_vld", 32'(ir_valid), 32'd0);
    chk("addr_top", mem_addr, 32'hFFFF_FFFC);
    chk("ld_ack_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'h0800_0010;
    tick();
    mem_ack = 1'b0;
    chk("irpc_top", ir_pc, 32'hFFFF_FFFC);
    chk("pc4_wrap", ir_pc_plus4, 32'h0);
    chk("opc_j", 32'(opcode), 32'h02);
    chk("jaddr", 32'(jaddr), 32'h10);
    ir_accept = 1'b1;
    tick();
    ir_accept = 1'b0;
    chk("addr_wrap", mem_addr, 32'h0);

    pc_load = 1'b1;
    pc_target = 32'h200;
    tick();
    pc_target = 32'h300;
    tick();
    pc_target = 32'h10;
    mem_ack = 1'b1;
    tick();
    pc_load = 1'b0;
    mem_ack = 1'b0;
    chk("last_win", mem_addr, 32'h10);
    chk("last_vld", 32'(ir_valid), 32'd0);

    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rst_req_lo", 32'(mem_req), 32'd0);
    tick();
    reset = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk("rst2_vld", 32'(ir_valid), 32'd0);
    chk("rst2_ir", ir, 32'h0);
    chk("rst2_irpc", ir_pc, 32'h0);
    chk("rst2_addr", mem_addr, 32'h0);
    chk("rst2_req", 32'(mem_req), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
